uart_tx_sched: RTL



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_sched_if.sv | 21 ++
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_tx_sched.sv | 117 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the shared UART transmitter: FSM encoding and baud sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Clock cycles per bit; integer truncation is intentional.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Valid/ready byte handshakes of the two requesters feeding the shared transmitter.
interface uart_tx_sched_if;

  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..DIV-1, wraps, and flags the last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIV = 434,
  parameter int W   = cnt_width(DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler for two byte sources sharing one 8N1 UART transmit line.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic           clk_50m,
  input  logic           rst,
  uart_tx_sched_if.slave bus,
  output logic           txd,
  output logic           busy,
  output logic           gnt_id
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = cnt_width(DIV);

  tx_state_e  state, state_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift_reg, shift_n;
  logic       txd_q, txd_n;
  logic       gnt_q, gnt_n;
  logic       last_served, last_n;
  logic       bit_end;
  logic       idle;

  assign idle = (state == IDLE);

  // On contention the requester that was not served last wins.
  assign bus.req0_ready = idle & bus.req0_valid & (~bus.req1_valid | last_served);
  assign bus.req1_ready = idle & bus.req1_valid & (~bus.req0_valid | ~last_served);

  // Held clear while idle so every frame's start bit begins from count 0.
  uart_baud_cnt #(.DIV(DIV), .W(CW)) u_baud (
    .clk     (clk_50m),
    .rst     (rst),
    .clear   (idle),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state       <= IDLE;
      bit_idx     <= 3'd0;
      shift_reg   <= 8'd0;
      txd_q       <= 1'b1;
      gnt_q       <= 1'b0;
      last_served <= 1'b1;
    end else begin
      state       <= state_n;
      bit_idx     <= bit_idx_n;
      shift_reg   <= shift_n;
      txd_q       <= txd_n;
      gnt_q       <= gnt_n;
      last_served <= last_n;
    end
  end

  // txd is computed for the next state so the line level changes on the same edge as the state.
  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    txd_n     = txd_q;
    gnt_n     = gnt_q;
    last_n    = last_served;
    unique case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (bus.req0_ready || bus.req1_ready) begin
          state_n   = START;
          shift_n   = bus.req1_ready ? bus.req1_data : bus.req0_data;
          gnt_n     = bus.req1_ready;
          last_n    = bus.req1_ready;
          bit_idx_n = 3'd0;
          txd_n     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
          txd_n     = shift_reg[0];
          shift_n   = {1'b0, shift_reg[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            txd_n     = shift_reg[0];
            shift_n   = {1'b0, shift_reg[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          txd_n   = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  assign txd    = txd_q;
  assign busy   = ~idle;
  assign gnt_id = gnt_q;

endmodule
